// File: rtl/add_share_ctrl.sv
// rtl/add_share_ctrl.sv - round-robin controller sharing one registered adder among N requesters
//
// Accepts one operand pair at a time from N requesters, issues it to a shared
// adder with fixed latency LAT, captures the sum and returns it with the
// requester index over a response handshake that supports backpressure.
// Only one transaction is in flight at any time.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid[N]           per-requester request valid
//   req_ready[N]           per-requester accept (one-hot or zero, IDLE only)
//   req_a/req_b[N*W]       operands, requester i at bits [i*W +: W]
//   add_start              one-cycle start pulse to the adder
//   add_a/add_b[W]         operands to the adder (hold last latched values)
//   add_y[W]               adder result, valid LAT cycles after the start cycle
//   rsp_valid/rsp_ready    response handshake
//   rsp_id[clog2(N)]       requester index of the response
//   rsp_data[W]            sum modulo 2^W
//
// Build option:
//   ARB_FIXED_PRIO_EN      when defined, the lowest valid index always wins;
//                          otherwise round-robin starting after the last grant.

module add_share_ctrl #(
    parameter int N   = 4,
    parameter int W   = 10,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*W-1:0]        req_a,
    input  logic [N*W-1:0]        req_b,
    output logic                  add_start,
    output logic [W-1:0]          add_a,
    output logic [W-1:0]          add_b,
    input  logic [W-1:0]          add_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [$clog2(N)-1:0]  rsp_id,
    output logic [W-1:0]          rsp_data
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [CW-1:0]  wait_cnt;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_any;
    logic [W-1:0]   op_a [N];
    logic [W-1:0]   op_b [N];

`ifndef ARB_FIXED_PRIO_EN
    logic [IDW-1:0] last_grant;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = req_a[i*W +: W];
            op_b[i] = req_b[i*W +: W];
        end
    end

    // Candidates are visited from the lowest-priority one to the highest, so
    // the last valid candidate seen is the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N; k >= 1; k--) begin
`ifdef ARB_FIXED_PRIO_EN
            cand = IDW'(k - 1);
`else
            cand = IDW'((int'(last_grant) + k) % N);
`endif
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The grant is only offered in IDLE; gating with rst_n keeps req_ready at
    // zero for the whole time reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            cur_id     <= '0;
            add_start  <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= IDW'(N - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        add_a      <= op_a[grant_idx];
                        add_b      <= op_b[grant_idx];
                        cur_id     <= grant_idx;
                        add_start  <= 1'b1;
                        state      <= ISSUE;
`ifndef ARB_FIXED_PRIO_EN
                        last_grant <= grant_idx;
`endif
                    end
                end
                ISSUE: begin
                    add_start <= 1'b0;
                    wait_cnt  <= CW'(LAT);
                    state     <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CW'(1);
                    // Counter at 1 marks the edge where add_y holds the sum.
                    if (wait_cnt == CW'(1)) begin
                        rsp_data  <= add_y;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_ctrl.sv
// tb/tb_add_share_ctrl.sv - self-checking bench for add_share_ctrl with a transaction-level model

module tb_add_share_ctrl;

    localparam int N   = 4;
    localparam int W   = 10;
    localparam int LAT = 2;
    localparam int IDW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic            add_start;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic [W-1:0]    add_y;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    add_share_ctrl #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_y(add_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared adder: two register stages; output is scrambled when not valid
    logic [W-1:0] s1 = '0;
    logic         v1 = 1'b0;
    always @(posedge clk) begin
        v1    <= add_start;
        s1    <= add_a + add_b;
        add_y <= v1 ? s1 : ~s1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_sum(input int a, input int b);
        return (a + b) % (1 << W);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
        if (last < 0) return -1;
`else
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    // Transaction-level model: age counts cycles since acceptance
    // (1 = issue cycle, LAT+2 and beyond = response offered).
    bit m_busy = 0;
    int m_age  = 0;
    int m_last = N - 1;
    int m_id   = 0;
    int m_a    = 0;
    int m_b    = 0;
    int m_g;
    int m_grants[$];
    int m_rsp_id[$];
    int m_rsp_data[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_last = N - 1; m_id = 0; m_a = 0; m_b = 0;
        end else if (!m_busy) begin
            m_g = pick(req_valid, m_last);
            if (m_g >= 0) begin
                m_busy = 1; m_age = 1; m_id = m_g; m_last = m_g;
                m_a = int'(req_a[m_g*W +: W]);
                m_b = int'(req_b[m_g*W +: W]);
                m_grants.push_back(m_g);
            end
        end else if (m_age >= LAT + 2) begin
            if (rsp_ready) begin
                m_busy = 0;
                m_rsp_id.push_back(m_id);
                m_rsp_data.push_back(exp_sum(m_a, m_b));
            end
        end else begin
            m_age++;
        end
    end

    // Compare process plus DUT-side logs
    logic [N-1:0] e_ready;
    int           e_pick;
    bit           e_rv;
    bit           prev_rv = 0;
    int           acc_cyc = 0;
    int           rise_cyc = 0;
    int           d_grants[$];
    int           d_rsp_id[$];
    int           d_rsp_data[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_add_start", add_start, 0);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            prev_rv = 0;
        end else begin
            e_pick  = pick(req_valid, m_last);
            e_ready = '0;
            if (!m_busy && e_pick >= 0) e_ready[e_pick] = 1'b1;
            e_rv = m_busy && (m_age >= LAT + 2);
            chk("req_ready", req_ready, e_ready);
            chk("add_start", add_start, m_busy && (m_age == 1));
            chk("add_a", add_a, m_a);
            chk("add_b", add_b, m_b);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, exp_sum(m_a, m_b));
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    d_grants.push_back(i);
                    acc_cyc = cyc + 1;
                end
            end
            if (rsp_valid && !prev_rv) rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                d_rsp_id.push_back(int'(rsp_id));
                d_rsp_data.push_back(int'(rsp_data));
            end
            prev_rv = rsp_valid;
        end
    end

    task automatic send(input int id, input int a, input int b);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) ok = 1;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        chk("send_accept_timeout", ok, 1);
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) ok = 1;
        end
        #1;
        chk(name, ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    int n3, rb, gstart;
    bit ok_rr;

    initial begin
        // Pin the model itself
        chk("model_sum_basic", exp_sum(5, 7), 12);
        chk("model_sum_wrap", exp_sum(1000, 30), 6);
        chk("model_pick_first", pick(4'b1111, N - 1), 0);
`ifdef ARB_FIXED_PRIO_EN
        chk("model_pick_skip", pick(4'b1010, 1), 1);
`else
        chk("model_pick_skip", pick(4'b1010, 1), 3);
`endif
        chk("model_pick_none", pick(4'b0000, 2), -1);

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        chk("reset_req_ready", req_ready, 0);
        chk("reset_add_start", add_start, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);

        // Single request
        rsp_ready = 1'b1;
        send(2, 5, 7);
        chk("single_add_start", add_start, 1);
        chk("single_add_a", add_a, 5);
        chk("single_add_b", add_b, 7);
        @(posedge clk); #1;
        chk("single_start_pulse", add_start, 0);
        wait_rsp("single_rsp_timeout");
        chk("single_rsp_id", rsp_id, 2);
        chk("single_rsp_data", rsp_data, 12);
        chk("single_latency", rise_cyc - acc_cyc, 3);
        @(posedge clk); #1;
        chk("single_resp_one_cycle", rsp_valid, 0);

        // Overflow wrap
        send(0, 1000, 30);
        wait_rsp("wrap_rsp_timeout");
        chk("wrap_rsp_id", rsp_id, 0);
        chk("wrap_rsp_data", rsp_data, 6);

        // Fairness with all requesters held valid
        do_reset();
        gstart = d_grants.size();
        @(posedge clk); #1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
        ok_rr = 0;
        for (int t = 0; t < 200 && !ok_rr; t++) begin
            @(negedge clk); #1;
            if (d_grants.size() >= gstart + 8) ok_rr = 1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("rr_timeout", ok_rr, 1);
        repeat (10) @(posedge clk);
        if (ok_rr) begin
            for (int i = 0; i < 8; i++) begin
`ifdef ARB_FIXED_PRIO_EN
                chk("rr_grant_order", d_grants[gstart + i], 0);
`else
                chk("rr_grant_order", d_grants[gstart + i], i % N);
`endif
            end
        end

        // Backpressure
        rsp_ready = 1'b0;
        send(2, 300, 400);
        req_valid[0] = 1'b1;
        wait_rsp("bp_rsp_timeout");
        for (int t = 0; t < 5; t++) begin
            @(negedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 2);
            chk("bp_rsp_data", rsp_data, 700);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_add_start", add_start, 0);
        end
        rb = d_rsp_id.size();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk); #1;
        chk("bp_handshake", d_rsp_id.size(), rb + 1);
        @(posedge clk); #1;
        chk("bp_done", rsp_valid, 0);

        // Withdrawn request while in RESP
        rsp_ready = 1'b0;
        send(0, 1, 1);
        wait_rsp("wd_rsp_timeout");
        n3 = 0;
        foreach (d_grants[i]) if (d_grants[i] == 3) n3++;
        rb = d_rsp_id.size();
        @(posedge clk); #1;
        req_valid[3] = 1'b1;
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        begin
            int n3b = 0;
            foreach (d_grants[i]) if (d_grants[i] == 3) n3b++;
            chk("wd_no_grant3", n3b, n3);
        end
        chk("wd_rsp_count", d_rsp_id.size(), rb + 1);
        chk("wd_rsp_id", d_rsp_id[d_rsp_id.size() - 1], 0);

        // Reset in the middle of WAIT
        send(1, 100, 200);
        @(posedge clk); #2;
        rb = d_rsp_id.size();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_add_start", add_start, 0);
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_add_b", add_b, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_rsp", d_rsp_id.size(), rb);
        send(1, 3, 4);
        wait_rsp("mid_rst_rsp_timeout");
        chk("mid_rst_rsp_id_after", rsp_id, 1);
        chk("mid_rst_rsp_data_after", rsp_data, 7);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        chk("grant_log_size", d_grants.size(), m_grants.size());
        if (d_grants.size() == m_grants.size())
            foreach (m_grants[i]) chk("grant_log", d_grants[i], m_grants[i]);
        chk("rsp_log_size", d_rsp_id.size(), m_rsp_id.size());
        if (d_rsp_id.size() == m_rsp_id.size()) begin
            foreach (m_rsp_id[i]) begin
                chk("rsp_log_id", d_rsp_id[i], m_rsp_id[i]);
                chk("rsp_log_data", d_rsp_data[i], m_rsp_data[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_share_ctrl.md
# add_share_ctrl

Round-robin controller that shares one registered two-operand adder (fixed 2-cycle start-to-result latency) between N requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and drives the adder's start/a/b inputs for one cycle. It then captures the adder result after the pipeline latency and returns it with the requester ID over a response handshake that supports backpressure. It sits between the requester ports and the adder instance, and only one transaction is in flight at a time.

## Interface
- N, 4, number of requesters (2..8)
- W, 10, operand/result width; must match adder W
- LAT, 2, adder latency in cycles from the add_start cycle to add_y valid
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  N  per-requester request valid
- req_ready  output  N  per-requester accept; one-hot or zero
- req_a  input  N*W  operand A; requester i occupies bits [i*W +: W]
- req_b  input  N*W  operand B; same packing as req_a
- add_start  output  1  one-cycle start pulse to the adder
- add_a  output  W  operand A to the adder
- add_b  output  W  operand B to the adder
- add_y  input  W  adder result
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  clog2(N)  requester index of the response
- rsp_data  output  W  sum, truncated to W bits

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready = grant vector: the first requester with req_valid set, searching upward from (last_grant+1) mod N with wrap-around.
  - When any requester is granted: latch its operands and its index, update last_grant, go to ISSUE.
  - When no requester is valid: stay in IDLE.
- ISSUE
  - add_start=1, add_a/add_b = latched operands, for exactly one cycle.
  - Load wait counter with LAT; go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1, capture add_y into rsp_data; go to RESP.
- RESP
  - rsp_valid=1; rsp_id and rsp_data are held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
- req_ready is 0 outside IDLE. The controller never issues a second start while a transaction is outstanding.
- A requester that drops req_valid before it is granted loses its turn, with no side effects.
- add_a/add_b hold the last latched values outside ISSUE, and add_start is 0.
- Arithmetic: no carry out; the sum wraps modulo 2^W.
- Reset mid-operation returns the FSM to IDLE asynchronously and discards the transaction. No response is produced for it.

## Timing
- Reset values:
  - req_ready=0, add_start=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - last_grant=N-1, so the first grant after reset goes to requester 0.
- Acceptance occurs at edge E0, when req_valid[i]&&req_ready[i]. add_start is high for the cycle between E0 and E1.
- With LAT=2:
  - WAIT spans the two cycles after E1.
  - add_y is sampled at E3.
  - rsp_valid is high from E3.
- Best-case throughput is one transaction per LAT+3 cycles (accept, issue, LAT waits, response). A new grant is possible in the cycle after the response handshake.
- If rsp_ready is held high on the first RESP cycle, RESP lasts exactly one cycle.

## Configuration
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest valid index always wins, and last_grant is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request: req 2 with a=5, b=7 -> add_start pulses 1 cycle after acceptance with add_a=5, add_b=7; rsp_valid rises 3 edges after acceptance with rsp_id=2, rsp_data=12.
- Overflow wrap: W=10, a=1000, b=30 -> rsp_data=6.
- Round-robin fairness: all 4 requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3. With ARB_FIXED_PRIO_EN defined -> all 8 grants go to 0.
- Backpressure: rsp_ready held low for 5 cycles -> rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0 and add_start stays 0; the response completes when rsp_ready rises.
- Reset mid-operation: assert rst_n low during WAIT -> all outputs return to reset values immediately; after release, a request from req 1 with a=3, b=4 yields rsp_id=1, rsp_data=7.
- Withdrawn request: req 3 valid for 1 cycle while the FSM is in RESP, then dropped -> no grant and no response for requester 3.
